// File: rtl/ecc_pkg.sv
// ecc_pkg: mode/error encodings and extended-Hamming H matrices shared by the decoder
package ecc_pkg;
  typedef enum logic [1:0] {MOD_8, MOD_16, MOD_32, MOD_ILL} mode_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_SINGLE, ERR_DOUBLE, ERR_ILL} err_e;
  localparam int CW_8 = 8;
  localparam int PW_8 = 4;
  localparam int CW_16 = 16;
  localparam int PW_16 = 5;
  localparam int CW_32 = 32;
  localparam int PW_32 = 6;
  localparam logic [5:0][31:0] H_8 = {32'h0, 32'h0, 32'hFF, 32'hE4, 32'hD2, 32'hB1};
  localparam logic [5:0][31:0] H_16 = {32'h0, 32'hFFFF, 32'hFE08, 32'hF1C4, 32'hCDA2, 32'hAB61};
  localparam logic [5:0][31:0] H_32 = {32'hFFFFFFFF, 32'hFFFE0010, 32'hFF01FC08,
                                       32'hF0F1E384, 32'hCCCD9B42, 32'hAAAB56C1};
  function automatic int mode_len(mode_e m);
    return m == MOD_8 ? CW_8 : m == MOD_16 ? CW_16 : CW_32;
  endfunction
  function automatic logic [31:0] h_row(mode_e m, logic [2:0] r);
    return m == MOD_8  && int'(r) < PW_8  ? H_8[r]  :
           m == MOD_16 && int'(r) < PW_16 ? H_16[r] :
           m == MOD_32 && int'(r) < PW_32 ? H_32[r] : 32'h0;
  endfunction
  function automatic logic h_bit(mode_e m, logic [2:0] r, logic [4:0] c);
    logic [31:0] row;
    row = h_row(m, r);
    return row[c];
  endfunction
endpackage

// File: rtl/ecc_dec_pipe_if.sv
// ecc_dec_pipe_if: input and output valid/ready streams of the decoder
interface ecc_dec_pipe_if #(parameter int MAX_CODEWORD_WIDTH = 32) ();
  logic in_valid;
  logic in_ready;
  logic [MAX_CODEWORD_WIDTH-1:0] data_in;
  logic [1:0] work_mod;
  logic out_valid;
  logic out_ready;
  logic [MAX_CODEWORD_WIDTH-1:0] data_out;
  logic [1:0] num_of_errors;
  modport slave (input in_valid, data_in, work_mod, out_ready,
                 output in_ready, out_valid, data_out, num_of_errors);
  modport master (output in_valid, data_in, work_mod, out_ready,
                  input in_ready, out_valid, data_out, num_of_errors);
endinterface

// File: rtl/ecc_syndrome_calc.sv
// ecc_syndrome_calc: syndrome of a masked codeword and one-hot match against the H columns
module ecc_syndrome_calc
  import ecc_pkg::*;
#(
  parameter int W = 32,
  parameter int P = 6
) (
  input  logic [W-1:0] data,
  input  mode_e        mode,
  output logic [P-1:0] syn,
  output logic [W-1:0] match
);
  always_comb begin
    syn = '0;
    for (int r = 0; r < P; r++) syn[r] = ^(data & W'(h_row(mode, 3'(r))));
  end
  for (genvar c = 0; c < W; c++) begin : g_col
    logic [P-1:0] col;
    always_comb begin
      col = '0;
      for (int r = 0; r < P; r++) col[r] = h_bit(mode, 3'(r), 5'(c));
    end
    assign match[c] = c < mode_len(mode) && mode != MOD_ILL && |syn && syn == col;
  end
endmodule

// File: rtl/ecc_dec_pipe.sv
// ecc_dec_pipe: two-stage extended-Hamming decoder with saturating error statistics
module ecc_dec_pipe
  import ecc_pkg::*;
#(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH = 26,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_dec_pipe_if.slave        bus,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] single_cnt,
  output logic [CNT_WIDTH-1:0] double_cnt
);
  localparam int W = MAX_CODEWORD_WIDTH;
  localparam int P = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;
  mode_e mode, s1_mode;
  err_e s2_err;
  logic s1_valid, s1_load, s2_load, deliver;
  logic [W-1:0] masked, match, s1_data, s1_match, s2_data;
  logic [P-1:0] syn, s1_syn;
  always_comb begin
    mode = mode_e'(bus.work_mod);
    for (int c = 0; c < W; c++) masked[c] = bus.data_in[c] && (mode == MOD_ILL || c < mode_len(mode));
  end
  ecc_syndrome_calc #(.W(W), .P(P)) u_syn (.data(masked), .mode(mode), .syn(syn), .match(match));
  assign s2_load = !bus.out_valid || bus.out_ready;
  assign s1_load = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;
  assign deliver = bus.out_valid && bus.out_ready;
  always_comb begin
    s2_err = s1_mode == MOD_ILL ? ERR_ILL : s1_syn == '0 ? ERR_NONE : |s1_match ? ERR_SINGLE : ERR_DOUBLE;
    s2_data = s2_err == ERR_SINGLE ? s1_data ^ s1_match : s1_data;
  end
  // stage-1 payload is left unreset; its valid bit guards every use
  always_ff @(posedge clk) begin
    if (bus.in_valid && s1_load) begin
      s1_data <= masked;
      s1_mode <= mode;
      s1_syn <= syn;
      s1_match <= match;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.data_out <= '0;
      bus.num_of_errors <= ERR_NONE;
    end else begin
      if (s1_load) s1_valid <= bus.in_valid;
      if (s2_load) bus.out_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        bus.data_out <= s2_data;
        bus.num_of_errors <= s2_err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      single_cnt <= '0;
      double_cnt <= '0;
    end else if (deliver) begin
      if (bus.num_of_errors == ERR_SINGLE && !(&single_cnt)) single_cnt <= single_cnt + 1'b1;
      if (bus.num_of_errors == ERR_DOUBLE && !(&double_cnt)) double_cnt <= double_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ecc_dec_pipe.sv
// tb_ecc_dec_pipe: randomized and directed checks of ecc_dec_pipe against a scoreboard model
module tb_ecc_dec_pipe;
  localparam int CW = 4;
  localparam int CMAX = 15;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cnt_clr = 1'b0;
  logic [CW-1:0] single_cnt, double_cnt;
  int n_chk = 0, n_pass = 0, n_del = 0, m_single = 0, m_double = 0;
  logic last_acc;
  logic [31:0] last_data;
  logic [1:0] last_err;
  logic [33:0] q[$];
  logic [31:0] hm[3][6] = '{'{32'hB1, 32'hD2, 32'hE4, 32'hFF, 32'h0, 32'h0},
                            '{32'hAB61, 32'hCDA2, 32'hF1C4, 32'hFE08, 32'hFFFF, 32'h0},
                            '{32'hAAAB56C1, 32'hCCCD9B42, 32'hF0F1E384, 32'hFF01FC08, 32'hFFFE0010, 32'hFFFFFFFF}};
  ecc_dec_pipe_if #(.MAX_CODEWORD_WIDTH(32)) bus ();
  ecc_dec_pipe #(.MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cnt_clr(cnt_clr), .single_cnt(single_cnt), .double_cnt(double_cnt));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  function automatic logic [33:0] ref_dec(logic [31:0] d, logic [1:0] m);
    int len;
    logic [31:0] x;
    logic [5:0] s, col;
    if (m == 2'd3) return {2'b11, d};
    len = 8 << m;
    x = len == 32 ? d : d & ((32'd1 << len) - 32'd1);
    s = '0;
    for (int r = 0; r < 6; r++) s[r] = $countones(x & hm[m][r]) % 2 == 1;
    if (s == 0) return {2'b00, x};
    for (int c = 0; c < len; c++) begin
      for (int r = 0; r < 6; r++) col[r] = hm[m][r][c];
      if (col == s) return {2'b01, x ^ (32'd1 << c)};
    end
    return {2'b10, x};
  endfunction
  task automatic tick();
    logic [33:0] e;
    logic del, clr, have;
    @(negedge clk);
    last_acc = bus.in_valid && bus.in_ready;
    del = bus.out_valid && bus.out_ready;
    clr = cnt_clr;
    have = 1'b0;
    e = '0;
    if (!rst) begin
      q.delete();
      m_single = 0;
      m_double = 0;
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) check("spurious_out", bus.out_valid, 0);
        else begin
          e = q[0];
          have = 1'b1;
          check("data_out", bus.data_out, e[31:0]);
          check("num_err", bus.num_of_errors, e[33:32]);
          if (del) begin
            void'(q.pop_front());
            n_del++;
            last_data = bus.data_out;
            last_err = bus.num_of_errors;
          end
        end
      end
      if (clr) begin
        m_single = 0;
        m_double = 0;
      end else if (del && have) begin
        if (e[33:32] == 2'b01 && m_single < CMAX) m_single++;
        if (e[33:32] == 2'b10 && m_double < CMAX) m_double++;
      end
      if (last_acc) q.push_back(ref_dec(bus.data_in, bus.work_mod));
    end
    @(posedge clk);
    #1;
    check("single_cnt", single_cnt, m_single);
    check("double_cnt", double_cnt, m_double);
  endtask
  task automatic send(logic [31:0] d, logic [1:0] m);
    bus.in_valid = 1'b1;
    bus.data_in = d;
    bus.work_mod = m;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) check("accept_timeout", last_acc, 1);
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    check("drain", q.size(), 0);
  endtask
  task automatic directed(logic [31:0] d, logic [1:0] m, logic [31:0] xd, logic [1:0] xe);
    send(d, m);
    drain();
    check("dir_data", last_data, xd);
    check("dir_err", last_err, xe);
  endtask
  initial begin
    logic [31:0] wd[4];
    logic [1:0] wm[4];
    int idx, d0, r;
    logic need;
    bus.in_valid = 1'b0;
    bus.data_in = '0;
    bus.work_mod = 2'b00;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_num_err", bus.num_of_errors, 0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    directed(32'h0, 2'b00, 32'h0, 2'b00);
    directed(32'h1, 2'b00, 32'h0, 2'b01);
    check("single_after_1", single_cnt, 1);
    directed(32'h3, 2'b00, 32'h3, 2'b10);
    check("double_after_1", double_cnt, 1);
    directed(32'hFFFFFF00, 2'b00, 32'h0, 2'b00);
    directed(32'h80000000, 2'b10, 32'h0, 2'b01);
    directed(32'h12345678, 2'b11, 32'h12345678, 2'b11);
    check("single_after_ill", single_cnt, 2);
    check("double_after_ill", double_cnt, 1);
    for (int k = 0; k < 4; k++) begin
      wd[k] = $urandom;
      wm[k] = 2'($urandom_range(0, 2));
    end
    bus.out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = idx < 4;
      bus.data_in = wd[idx % 4];
      bus.work_mod = wm[idx % 4];
      tick();
      if (last_acc) idx++;
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    d0 = n_del;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = idx < 4;
      bus.data_in = wd[idx % 4];
      bus.work_mod = wm[idx % 4];
      tick();
      if (last_acc) idx++;
    end
    bus.in_valid = 1'b0;
    check("bp_delivered", n_del - d0, 4);
    check("bp_all_accepted", idx, 4);
    need = 1'b1;
    for (int k = 0; k < 400; k++) begin
      bus.out_ready = $urandom_range(0, 3) != 0;
      if (need) begin
        r = $urandom_range(0, 9);
        bus.in_valid = $urandom_range(0, 3) != 0;
        bus.data_in = $urandom;
        bus.work_mod = r == 0 ? 2'b11 : 2'(r % 3);
      end
      tick();
      need = last_acc || !bus.in_valid;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int k = 0; k < 17; k++) send(32'h1, 2'b00);
    drain();
    check("single_sat", single_cnt, 15);
    send(32'h1, 2'b00);
    for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_priority", single_cnt, 0);
    send(32'h3, 2'b00);
    bus.in_valid = 1'b1;
    bus.data_in = 32'h1;
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_single", single_cnt, 0);
    check("midrst_double", double_cnt, 0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    directed(32'h2, 2'b00, 32'h0, 2'b01);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
